// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch port and the data port, with a wait watchdog.
// Build option: define ARB_RR_EN for round-robin tie breaking (default: data port wins ties).
module mem_port_arbiter #(
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter int                 TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0]  ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

  state_t     state_r;
  logic [7:0] wait_cnt_r;
  logic       grant_d_s;

`ifdef ARB_RR_EN
  logic       last_d_r;  // 1: data port was granted last, so fetch wins the next tie

  // Grant decision for an IDLE cycle, round-robin on ties
  always_comb begin
    grant_d_s = 1'b0;
    if (d_req && if_req) begin
      grant_d_s = !last_d_r;
    end else if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
  end
`else
  // Grant decision for an IDLE cycle, data port wins ties
  always_comb begin
    grant_d_s = 1'b0;
    if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
  end
`endif

  // Access sequencer: grant, wait for mem_ack or watchdog abort, respond
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 8'd0;
      if_rdata    <= '0;
      if_ready    <= 1'b0;
      d_rdata     <= '0;
      d_ready     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
`ifdef ARB_RR_EN
      last_d_r    <= 1'b1;
`endif
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (if_req || d_req) begin
            mem_req    <= 1'b1;
            wait_cnt_r <= 8'd0;
`ifdef ARB_RR_EN
            last_d_r   <= grant_d_s;
`endif
            if (grant_d_s) begin
              state_r   <= BUSY_D;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state_r   <= BUSY_IF;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (mem_ack || (wait_cnt_r == LAST_CNT)) begin
            // Completion and abort share the exit path; only the returned data differs
            mem_req <= 1'b0;
            state_r <= RESP;
            if (!mem_ack) begin
              timeout_err <= 1'b1;
            end
            if (state_r == BUSY_D) begin
              d_ready <= 1'b1;
              if (!mem_we) begin
                d_rdata <= mem_ack ? mem_rdata : ERR_DATA;
              end
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : ERR_DATA;
            end
          end else if (wait_cnt_r != 8'hFF) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of single accesses plus reset, tie and stray-ack sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        timeout_err;

  localparam int TMO = 4;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;   // cycles from mem_req to mem_ack; -1 = never ack
    logic [31:0] mrd;     // memory data for reads of locations never stored
    logic [31:0] exp_rd;  // expected rdata for reads
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] model_if_rdata = 32'd0;
  logic [31:0] model_d_rdata = 32'd0;
  logic [31:0] mem_model [logic [31:0]];
  exp_t        sb[$];
  vec_t        vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_if_ready"}, 32'(if_ready), 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_d_ready"}, 32'(d_ready), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // One complete access on one port; caller is at a negedge with the DUT idle
  task automatic access(input vec_t v);
    int   t;
    int   k;
    logic ready_s;
    logic abort_s;
    exp_t e;
    abort_s = (v.delay < 0) || (v.delay >= TMO);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    e.is_d  = v.is_d;
    e.rdata = (v.is_d && v.we) ? model_d_rdata : v.exp_rd;
    sb.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_req && t < 10);
    chk("grant_latency", 32'(t), 32'd1);
    chk("mem_addr", mem_addr, v.addr);
    chk("mem_we", 32'(mem_we), 32'(v.is_d & v.we));
    chk("mem_wdata", mem_wdata, (v.is_d && v.we) ? v.wdata : 32'd0);
    k = 0;
    ready_s = 1'b0;
    while (!ready_s && k < 300) begin
      mem_ack = (k == v.delay);
      if (mem_ack) begin
        if (v.is_d && v.we) begin
          mem_model[v.addr] = v.wdata;
          mem_rdata = 32'h1234_5678;
        end else begin
          mem_rdata = mem_model.exists(v.addr) ? mem_model[v.addr] : v.mrd;
        end
      end
      @(negedge clk);
      k++;
      ready_s = v.is_d ? d_ready : if_ready;
    end
    mem_ack = 1'b0;
    chk("ready_latency", 32'(k), abort_s ? 32'(TMO) : 32'(v.delay + 1));
    chk("mem_req_done", 32'(mem_req), 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(v.exp_err));
    e = sb.pop_front();
    if (e.is_d) begin
      chk("d_rdata", d_rdata, e.rdata);
      chk("if_ready_idle", 32'(if_ready), 32'd0);
      chk("if_rdata_kept", if_rdata, model_if_rdata);
      model_d_rdata = e.rdata;
    end else begin
      chk("if_rdata", if_rdata, e.rdata);
      chk("d_ready_idle", 32'(d_ready), 32'd0);
      chk("d_rdata_kept", d_rdata, model_d_rdata);
      model_if_rdata = e.rdata;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    chk("ready_pulse_if", 32'(if_ready), 32'd0);
    chk("ready_pulse_d", 32'(d_ready), 32'd0);
  endtask

  initial begin
    int   t;
    logic exp_d;
    exp_t e;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000,  3, 32'h0050_0093, 32'h0050_0093, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D,  1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000,  0, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000,  0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000,  2, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0080, 32'h0000_0000,  0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0000_0000, -1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0000_0000,  0, 32'h1357_9BDF, 32'h1357_9BDF, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0000_0000,  4, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 32'h0000_0048, 32'h5555_AAAA, -1, 32'h0000_0000, 32'h0000_0000, 1'b1};

    reset = 1'b0; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      access(vecs[i]);
    end

    // Stray mem_ack while idle must be ignored
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_if_ready", 32'(if_ready), 32'd0);
    chk("stray_d_ready", 32'(d_ready), 32'd0);
    chk("stray_mem_req", 32'(mem_req), 32'd0);
    chk("stray_if_rdata", if_rdata, model_if_rdata);
    chk("stray_d_rdata", d_rdata, model_d_rdata);

    // Reset in the middle of a fetch; the late ack must not produce a pulse
    if_req = 1'b1;
    if_addr = 32'h0000_0200;
    @(negedge clk);
    chk("rst_seq_busy", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 1'b1;
    if_req = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_if_ready", 32'(if_ready), 32'd0);
    chk("late_ack_if_rdata", if_rdata, 32'd0);
    chk("late_ack_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("late_ack_if_ready2", 32'(if_ready), 32'd0);
    model_if_rdata = 32'd0;
    model_d_rdata  = 32'd0;

    // Both ports held: four grants, arbitration pattern checked each time
    if_req = 1'b1; if_addr = 32'h0000_0500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600; d_wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!mem_req && t < 10);
      chk("tie_grant", 32'(mem_req), 32'd1);
`ifdef ARB_RR_EN
      exp_d = (i % 2) == 1;
`else
      exp_d = 1'b1;
`endif
      chk("tie_winner", mem_addr, exp_d ? 32'h0000_0600 : 32'h0000_0500);
      mem_ack = 1'b1;
      mem_rdata = 32'hC0DE_0000 + 32'(i);
      e.is_d = exp_d;
      e.rdata = mem_rdata;
      sb.push_back(e);
      @(negedge clk);
      mem_ack = 1'b0;
      e = sb.pop_front();
      if (e.is_d) begin
        chk("tie_d_ready", 32'(d_ready), 32'd1);
        chk("tie_if_ready", 32'(if_ready), 32'd0);
        chk("tie_d_rdata", d_rdata, e.rdata);
        chk("tie_if_rdata_kept", if_rdata, model_if_rdata);
        model_d_rdata = e.rdata;
      end else begin
        chk("tie_if_ready", 32'(if_ready), 32'd1);
        chk("tie_d_ready", 32'(d_ready), 32'd0);
        chk("tie_if_rdata", if_rdata, e.rdata);
        chk("tie_d_rdata_kept", d_rdata, model_d_rdata);
        model_if_rdata = e.rdata;
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    access('{1'b0, 1'b0, 32'h0000_0300, 32'h0000_0000, 1, 32'h0000_0013, 32'h0000_0013, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
